mpu_init_seq: RTL and testbench

Boot-time register sequencer for the MPU IMU, sitting directly upstream of `spi_mpu_set`. After reset it walks a fixed 7-entry table of (register address, data) pairs. For each entry it drives the `spi_mpu_set` start/addr/data inputs and waits for that block's finish pulse before moving on. It reports progress, completion and a timeout fault to the flight-control logic, and can be re-run on command.

---
 rtl/mpu_init_seq.sv | 155 +++++++++++++++
 tb/tb_mpu_init_seq.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_init_seq.sv
// Boot-time register sequencer for the MPU IMU: replays a fixed 7-entry
// (address, data) table through spi_mpu_set under per-entry timeout supervision.
module mpu_init_seq #(
  parameter int unsigned POR_CYCLES     = 100,
  parameter int unsigned RESET_GAP      = 1000,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       spi_busy,
  input  logic       spi_finish,
  output logic       spi_start,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] index
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_POR = 3'd1,
    START    = 3'd2,
    WAIT_ACK = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [15:0] POR_LD     = 16'(POR_CYCLES);
  localparam logic [15:0] RST_GAP_LD = 16'(RESET_GAP);
  localparam logic [15:0] GAP_LD     = 16'(GAP_CYCLES);
  localparam logic [15:0] TMO_LD     = 16'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAST_ENTRY = 3'd6;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] tmo;
  logic [2:0]  next_index;
  logic [15:0] next_entry;

  // {address, data}; bit 7 of the address stays 0 so every entry is a write
  function automatic logic [15:0] table_entry(input logic [2:0] i);
    logic [15:0] e;
    case (i)
      3'd0:    e = 16'h6B80;
      3'd1:    e = 16'h6B01;
      3'd2:    e = 16'h6A10;
      3'd3:    e = 16'h1900;
      3'd4:    e = 16'h1A03;
      3'd5:    e = 16'h1B18;
      3'd6:    e = 16'h1C08;
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  assign next_index = index + 3'd1;
  assign next_entry = table_entry(next_index);

  // Sequencer state, counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      tmo       <= 16'd0;
      spi_start <= 1'b0;
      spi_addr  <= 8'h00;
      spi_data  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      index     <= 3'd0;
    end else begin
      spi_start <= 1'b0;
      // The timeout spans both waiting for busy to clear and waiting for finish
      if ((state == START || state == WAIT_ACK) && tmo != 16'd0) begin
        tmo <= tmo - 16'd1;
      end
      case (state)
        IDLE: begin
          state <= WAIT_POR;
          cnt   <= POR_LD;
          busy  <= 1'b1;
        end
        WAIT_POR: begin
          if (cnt == 16'd0) begin
            state                <= START;
            index                <= 3'd0;
            {spi_addr, spi_data} <= table_entry(3'd0);
            tmo                  <= TMO_LD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        START: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            state     <= WAIT_ACK;
          end else if (tmo == 16'd0) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end
        end
        WAIT_ACK: begin
          // A finish in the expiry cycle still counts as success
          if (spi_finish) begin
            state <= GAP;
            cnt   <= (index == 3'd0) ? RST_GAP_LD : GAP_LD;
          end else if (tmo == 16'd0) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt == 16'd0) begin
            if (index == LAST_ENTRY) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state                <= START;
              index                <= next_index;
              {spi_addr, spi_data} <= next_entry;
              tmo                  <= TMO_LD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE, FAULT: begin
          if (go) begin
            state                <= START;
            done                 <= 1'b0;
            fault                <= 1'b0;
            busy                 <= 1'b1;
            index                <= 3'd0;
            {spi_addr, spi_data} <= table_entry(3'd0);
            tmo                  <= TMO_LD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_init_seq.sv
// Self-checking bench for mpu_init_seq: a slave model answers spi_start with
// spi_finish and a scoreboard of expected (addr, data, spacing) per start.
module tb_mpu_init_seq;

  localparam int POR = 4, RGAP = 20, GAP = 2, TMO = 50, SLV_DELAY = 10;

  logic       clk = 1'b0, rst = 1'b0, go = 1'b0;
  logic       spi_busy = 1'b0, spi_finish = 1'b0;
  logic       spi_start, busy, done, fault;
  logic [7:0] spi_addr, spi_data;
  logic [2:0] index;

  mpu_init_seq #(
    .POR_CYCLES(POR), .RESET_GAP(RGAP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .spi_busy(spi_busy), .spi_finish(spi_finish),
    .spi_start(spi_start), .spi_addr(spi_addr), .spi_data(spi_data),
    .busy(busy), .done(done), .fault(fault), .index(index)
  );

  always #5 clk = ~clk;

  // Rising-edge counter: at a falling edge it holds the number of the last rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tb_addr [7] = '{8'h6B, 8'h6B, 8'h6A, 8'h19, 8'h1A, 8'h1B, 8'h1C};
  logic [7:0] tb_data [7] = '{8'h80, 8'h01, 8'h10, 8'h00, 8'h03, 8'h18, 8'h08};

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;   // rising edges from reference to start; -1: start on busy release
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int run_ref = 0;

  // Slave controls, written only by the test sequence
  logic hang_en = 1'b0, coin_en = 1'b0, hold_en = 1'b0, stray_en = 1'b0;

  // Slave state, written only by the slave model
  int         pend = 0, hold = 0, stray_in = 0;
  logic       hung = 1'b0;
  int         fin_edge = 0, busy_fall_edge = 0;
  logic [7:0] cur_addr = 8'h00, cur_data = 8'h00;

  // Slave model; fin_edge is the rising edge that samples the finish pulse
  always @(negedge clk) begin
    spi_finish = 1'b0;
    if (!rst) begin
      pend = 0; hold = 0; stray_in = 0; hung = 1'b0;
    end else begin
      if (hung && !hang_en) hung = 1'b0;
      if (stray_in > 0) begin
        stray_in--;
        if (stray_in == 0) spi_finish = 1'b1;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) busy_fall_edge = cyc + 1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          spi_finish = 1'b1;
          fin_edge = cyc + 1;
          if (hold_en && cur_addr == 8'h6B && cur_data == 8'h01) hold = 15;
          if (stray_en && cur_addr == 8'h19) stray_in = 2;
        end
      end
      if (spi_start) begin
        cur_addr = spi_addr;
        cur_data = spi_data;
        if (hang_en && spi_addr == 8'h19) hung = 1'b1;
        else if (coin_en && spi_addr == 8'h19) pend = TMO - 1;
        else pend = SLV_DELAY;
      end
    end
    spi_busy = (pend > 0) || hung || (hold > 0);
  end

  int         n_obs;
  logic [7:0] obs_addr [16];
  logic [7:0] obs_data [16];
  int         obs_edge [16];
  int         obs_fin  [16];

  task automatic push_run(input int first_gap);
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      e.addr = tb_addr[i];
      e.data = tb_data[i];
      e.gap  = (i == 0) ? first_gap : (i == 1) ? RGAP + 2 : GAP + 2;
      exp_q.push_back(e);
    end
  endtask

  // Records up to n starts; pulses go on the cycle after start number go_at
  task automatic collect(input int n, input int go_at);
    int budget;
    budget = 2000;
    n_obs = 0;
    while (n_obs < n && budget > 0) begin
      @(negedge clk);
      budget--;
      go = 1'b0;
      if (spi_start === 1'b1) begin
        obs_addr[n_obs] = spi_addr;
        obs_data[n_obs] = spi_data;
        obs_edge[n_obs] = cyc;
        obs_fin[n_obs]  = fin_edge;
        if (n_obs == go_at) go = 1'b1;
        n_obs++;
      end
    end
    if (go) begin
      @(negedge clk);
      go = 1'b0;
    end
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    run_ref = cyc + 1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_start, busy, done, fault, index, spi_addr, spi_data} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {spi_start, busy, done, fault, index, spi_addr, spi_data});
    end
    rst = 1'b1;
    run_ref = cyc + 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL por_busy: got %b required 1", busy);
    end
  endtask

  task automatic test_full_sequence();
    exp_t e;
    int ref_edge, exp_edge, budget;
    push_run(POR + 2);
    collect(7, -1);
    checks++;
    if (n_obs != 7) begin
      failures++;
      $display("FAIL full_start_count: got %0d required 7", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      ref_edge = (i == 0) ? run_ref : obs_fin[i];
      exp_edge = (e.gap < 0) ? busy_fall_edge : ref_edge + e.gap;
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data}) begin
        failures++;
        $display("FAIL full_entry%0d: got %h required %h", i, {obs_addr[i], obs_data[i]}, {e.addr, e.data});
      end
      checks++;
      if (obs_edge[i] != exp_edge) begin
        failures++;
        $display("FAIL full_spacing%0d: got edge %0d required %0d", i, obs_edge[i], exp_edge);
      end
    end
    exp_q.delete();
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (done !== 1'b1 || cyc - fin_edge != GAP + 1) begin
      failures++;
      $display("FAIL full_done: got done=%b after %0d edges required 1 after %0d", done, cyc - fin_edge, GAP + 1);
    end
    checks++;
    if ({busy, fault, index} !== {1'b0, 1'b0, 3'd6}) begin
      failures++;
      $display("FAIL full_final: got busy=%b fault=%b index=%0d required 0 0 6", busy, fault, index);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int budget, extra;
    hang_en = 1'b1;
    push_run(1);
    pulse_go();
    collect(4, -1);
    checks++;
    if (n_obs != 4) begin
      failures++;
      $display("FAIL tmo_start_count: got %0d required 4", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data}) begin
        failures++;
        $display("FAIL tmo_entry%0d: got %h required %h", i, {obs_addr[i], obs_data[i]}, {e.addr, e.data});
      end
    end
    exp_q.delete();
    extra = 0;
    budget = 200;
    while (fault !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (spi_start === 1'b1) extra++;
    end
    // START was entered one edge before the start pulse; fault lands TMO+1 edges later
    checks++;
    if (fault !== 1'b1 || cyc != obs_edge[3] - 1 + TMO + 1) begin
      failures++;
      $display("FAIL tmo_fault_time: got fault=%b at edge %0d required 1 at %0d", fault, cyc, obs_edge[3] + TMO);
    end
    checks++;
    if ({index, busy, done} !== {3'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL tmo_state: got index=%0d busy=%b done=%b required 3 0 0", index, busy, done);
    end
    repeat (20) begin
      @(negedge clk);
      if (spi_start === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL tmo_extra_start: got %0d required 0", extra);
    end
    hang_en = 1'b0;
    repeat (2) @(negedge clk);
    pulse_go();
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fault_clear: got %b required 0", fault);
    end
    collect(7, -1);
    checks++;
    if (n_obs != 7 || {obs_addr[0], obs_data[0]} !== 16'h6B80) begin
      failures++;
      $display("FAIL tmo_restart: got %0d starts first %h required 7 first 6b80", n_obs, {obs_addr[0], obs_data[0]});
    end
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL tmo_restart_done: got %b required 1", done);
    end
  endtask

  task automatic test_busy_hold();
    exp_t e;
    int ref_edge, exp_edge, budget;
    hold_en = 1'b1;
    push_run(1);
    exp_q[2].gap = -1;
    pulse_go();
    collect(7, -1);
    checks++;
    if (n_obs != 7) begin
      failures++;
      $display("FAIL hold_start_count: got %0d required 7", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      ref_edge = (i == 0) ? run_ref : obs_fin[i];
      exp_edge = (e.gap < 0) ? busy_fall_edge : ref_edge + e.gap;
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data} || obs_edge[i] != exp_edge) begin
        failures++;
        $display("FAIL hold_entry%0d: got %h at %0d required %h at %0d",
                 i, {obs_addr[i], obs_data[i]}, obs_edge[i], {e.addr, e.data}, exp_edge);
      end
    end
    exp_q.delete();
    hold_en = 1'b0;
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if ({done, fault} !== 2'b10) begin
      failures++;
      $display("FAIL hold_done: got done=%b fault=%b required 1 0", done, fault);
    end
  endtask

  task automatic test_coincident();
    exp_t e;
    int ref_edge, exp_edge, budget;
    coin_en = 1'b1;
    push_run(1);
    pulse_go();
    collect(7, -1);
    checks++;
    if (n_obs != 7) begin
      failures++;
      $display("FAIL coin_start_count: got %0d required 7", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      ref_edge = (i == 0) ? run_ref : obs_fin[i];
      exp_edge = ref_edge + e.gap;
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data} || obs_edge[i] != exp_edge) begin
        failures++;
        $display("FAIL coin_entry%0d: got %h at %0d required %h at %0d",
                 i, {obs_addr[i], obs_data[i]}, obs_edge[i], {e.addr, e.data}, exp_edge);
      end
    end
    exp_q.delete();
    coin_en = 1'b0;
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if ({done, fault} !== 2'b10) begin
      failures++;
      $display("FAIL coin_done: got done=%b fault=%b required 1 0", done, fault);
    end
  endtask

  task automatic test_ignored_inputs();
    exp_t e;
    int ref_edge, exp_edge, budget;
    stray_en = 1'b1;
    push_run(1);
    pulse_go();
    collect(7, 2);
    checks++;
    if (n_obs != 7) begin
      failures++;
      $display("FAIL ign_start_count: got %0d required 7", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      ref_edge = (i == 0) ? run_ref : obs_fin[i];
      exp_edge = ref_edge + e.gap;
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data} || obs_edge[i] != exp_edge) begin
        failures++;
        $display("FAIL ign_entry%0d: got %h at %0d required %h at %0d",
                 i, {obs_addr[i], obs_data[i]}, obs_edge[i], {e.addr, e.data}, exp_edge);
      end
    end
    exp_q.delete();
    stray_en = 1'b0;
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if ({done, fault, index} !== {1'b1, 1'b0, 3'd6}) begin
      failures++;
      $display("FAIL ign_done: got done=%b fault=%b index=%0d required 1 0 6", done, fault, index);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ref_edge, exp_edge, budget, extra;
    pulse_go();
    collect(5, -1);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, index} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL rmid_pre: got busy=%b index=%0d required 1 4", busy, index);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({spi_start, busy, done, fault, index, spi_addr, spi_data} !== 23'd0) begin
      failures++;
      $display("FAIL rmid_outputs: got %h required 0",
               {spi_start, busy, done, fault, index, spi_addr, spi_data});
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (spi_start === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL rmid_start_in_reset: got %0d required 0", extra);
    end
    rst = 1'b1;
    run_ref = cyc + 1;
    push_run(POR + 2);
    collect(7, -1);
    checks++;
    if (n_obs != 7) begin
      failures++;
      $display("FAIL rmid_start_count: got %0d required 7", n_obs);
    end
    for (int i = 0; i < n_obs; i++) begin
      e = exp_q.pop_front();
      ref_edge = (i == 0) ? run_ref : obs_fin[i];
      exp_edge = ref_edge + e.gap;
      checks++;
      if ({obs_addr[i], obs_data[i]} !== {e.addr, e.data} || obs_edge[i] != exp_edge) begin
        failures++;
        $display("FAIL rmid_entry%0d: got %h at %0d required %h at %0d",
                 i, {obs_addr[i], obs_data[i]}, obs_edge[i], {e.addr, e.data}, exp_edge);
      end
    end
    exp_q.delete();
    budget = 200;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if ({done, busy, index} !== {1'b1, 1'b0, 3'd6}) begin
      failures++;
      $display("FAIL rmid_done: got done=%b busy=%b index=%0d required 1 0 6", done, busy, index);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_timeout();
    test_busy_hold();
    test_coincident();
    test_ignored_inputs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
